// File: rtl/iserdes_train_pkg.sv
// Shared state encoding and default constants for the ISERDES word-alignment trainer.
package iserdes_train_pkg;

  localparam int         DEF_WIDTH         = 10;
  localparam logic [9:0] DEF_TRAIN_PATTERN = 10'h3E0;
  localparam int         DEF_MATCH_COUNT   = 8;
  localparam int         DEF_SETTLE_WORDS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_COMPARE,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } train_state_t;

  function automatic logic is_busy(train_state_t s);
    return (s == ST_WAIT_READY) || (s == ST_COMPARE) || (s == ST_SLIP) || (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/iserdes_bitslip_ctrl.sv
// Word-alignment trainer: compares deserialized words with a training pattern and
// issues single-cycle active-low bitslip pulses until the pattern locks or slips run out.
module iserdes_bitslip_ctrl
  import iserdes_train_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(DEF_TRAIN_PATTERN),
  parameter int               MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int               SETTLE_WORDS  = DEF_SETTLE_WORDS,
  parameter int               MAX_SLIPS     = WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             ser_ready_i,
  input  logic [WIDTH-1:0]                 rx_word_i,
  input  logic                             rx_word_valid_i,
  output logic                             bitslip_n_o,
  output logic                             aligned_o,
  output logic                             train_fail_o,
  output logic                             busy_o,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count_o
);

  localparam int SLIP_W   = $clog2(MAX_SLIPS + 1);
  localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_WORDS + 1);

  localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_WORDS - 1);

  train_state_t        state_reg, state_next;
  logic [MATCH_W-1:0]  match_cnt_reg, match_cnt_next;
  logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [SLIP_W-1:0]   slip_cnt_reg, slip_cnt_next;
  logic                restart;

  always_comb begin
    state_next      = state_reg;
    match_cnt_next  = match_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    slip_cnt_next   = slip_cnt_reg;
    restart         = 1'b0;

    case (state_reg)
      ST_IDLE, ST_FAIL: restart = start;
      ST_LOCKED:        restart = start || !ser_ready_i;
      ST_WAIT_READY: begin
        if (ser_ready_i) begin
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!ser_ready_i) begin
          restart = 1'b1;
        end else if (rx_word_valid_i) begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next      = ST_COMPARE;
            settle_cnt_next = '0;
            match_cnt_next  = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
          end
        end
      end
      ST_COMPARE: begin
        if (!ser_ready_i) begin
          restart = 1'b1;
        end else if (rx_word_valid_i) begin
          if (rx_word_i == TRAIN_PATTERN) begin
            match_cnt_next = match_cnt_reg + MATCH_W'(1);
            if (match_cnt_reg == MATCH_LAST) begin
              state_next = ST_LOCKED;
            end
          end else begin
            match_cnt_next = '0;
            state_next     = (slip_cnt_reg < SLIP_MAX) ? ST_SLIP : ST_FAIL;
          end
        end
      end
      ST_SLIP: begin
        // The pulse is one registered cycle long whatever ser_ready_i does.
        if (slip_cnt_reg != SLIP_MAX) begin
          slip_cnt_next = slip_cnt_reg + SLIP_W'(1);
        end
        if (!ser_ready_i) begin
          restart = 1'b1;
        end else begin
          state_next      = ST_SETTLE;
          settle_cnt_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (restart) begin
      state_next      = ST_WAIT_READY;
      match_cnt_next  = '0;
      settle_cnt_next = '0;
      slip_cnt_next   = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      match_cnt_reg  <= '0;
      settle_cnt_reg <= '0;
      slip_cnt_reg   <= '0;
      bitslip_n_o    <= 1'b1;
      aligned_o      <= 1'b0;
      train_fail_o   <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      match_cnt_reg  <= match_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      slip_cnt_reg   <= slip_cnt_next;
      bitslip_n_o    <= (state_next != ST_SLIP);
      aligned_o      <= (state_next == ST_LOCKED);
      train_fail_o   <= (state_next == ST_FAIL);
      busy_o         <= is_busy(state_next);
    end
  end

  assign slip_count_o = slip_cnt_reg;

endmodule

// File: tb/tb_iserdes_bitslip_ctrl.sv
// Bench for iserdes_bitslip_ctrl: a rotating-window link model feeds words, a scoreboard
// holds expected slip pulses and run outcomes, and a monitor checks them as they appear.
module tb_iserdes_bitslip_ctrl;

  localparam int         W        = 10;
  localparam logic [9:0] TRAIN    = 10'h3E0;
  localparam logic [9:0] BAD      = 10'h155;
  localparam int         MATCH_N  = 8;
  localparam int         SETTLE_N = 4;
  localparam int         MAX_SL   = 10;
  localparam int         BUDGET   = 3000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         ser_ready_i;
  logic [W-1:0] rx_word_i;
  logic         rx_word_valid_i;
  logic         bitslip_n_o;
  logic         aligned_o;
  logic         train_fail_o;
  logic         busy_o;
  logic [3:0]   slip_count_o;

  always #5 clk = ~clk;

  iserdes_bitslip_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .ser_ready_i     (ser_ready_i),
    .rx_word_i       (rx_word_i),
    .rx_word_valid_i (rx_word_valid_i),
    .bitslip_n_o     (bitslip_n_o),
    .aligned_o       (aligned_o),
    .train_fail_o    (train_fail_o),
    .busy_o          (busy_o),
    .slip_count_o    (slip_count_o)
  );

  typedef enum int {EV_PULSE, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       words;
    int       aligned;
    int       fail;
    int       slips;
  } ev_t;

  ev_t sb[$];
  int  compared = 0;
  int  mismatched = 0;
  int  pulse_count = 0;
  int  done_count = 0;
  int  ph = 0;            // bits the receive window still has to slip to be aligned
  bit  never_match = 1'b0;
  int  valid_mode = 0;
  int  hold_invalid = 0;
  bit  ready_drv = 1'b1;
  int  cyc = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [W-1:0] rot(input logic [W-1:0] w, input int n);
    logic [2*W-1:0] d;
    d = {w, w};
    return d[n +: W];
  endfunction

  task automatic step(input bit st);
    @(posedge clk);
    #1;
    cyc++;
    start       = st;
    ser_ready_i = ready_drv;
    if (hold_invalid > 0) begin
      rx_word_valid_i = 1'b0;
      hold_invalid--;
    end else if (valid_mode == 0) begin
      rx_word_valid_i = 1'b1;
    end else if (valid_mode == 1) begin
      rx_word_valid_i = (cyc % 3 == 0);
    end else begin
      rx_word_valid_i = 1'($urandom_range(0, 1));
    end
    if (rx_word_valid_i) rx_word_i = never_match ? BAD : rot(TRAIN, ph);
    else                 rx_word_i = W'($urandom);
    @(negedge clk);
    if (reset_n && !bitslip_n_o) ph = (ph + W - 1) % W;
  endtask

  task automatic push_pulse();
    ev_t e;
    e.kind = EV_PULSE; e.words = SETTLE_N + 1; e.aligned = 0; e.fail = 0; e.slips = 0;
    sb.push_back(e);
  endtask

  // A window k bits off needs k slips; a stream that never matches burns every slip.
  task automatic push_run(input int nslips, input bit fails);
    ev_t e;
    for (int i = 0; i < nslips; i++) push_pulse();
    e.kind    = EV_DONE;
    e.words   = fails ? SETTLE_N + 1 : SETTLE_N + MATCH_N;
    e.aligned = fails ? 0 : 1;
    e.fail    = fails ? 1 : 0;
    e.slips   = nslips;
    sb.push_back(e);
  endtask

  task automatic launch(input int offset, input bit fails, input int vmode);
    ph = offset; never_match = fails; valid_mode = vmode; hold_invalid = 3;
    step(1'b1);
    step(1'b0);
    chk("start_busy", busy_o, 1);
    chk("start_slip_count", slip_count_o, 0);
    chk("start_aligned", aligned_o, 0);
    chk("start_fail", train_fail_o, 0);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_count < target && n < BUDGET) begin
      step(1'b0);
      n++;
    end
    chk({"done_in_time_", tag}, int'(done_count >= target), 1);
    if (done_count < target) sb.delete();
  endtask

  task automatic wait_pulses(input int target, input string tag);
    int n = 0;
    while (pulse_count < target && n < BUDGET) begin
      step(1'b0);
      n++;
    end
    chk({"pulses_in_time_", tag}, int'(pulse_count >= target), 1);
  endtask

  task automatic run_train(input int offset, input bit fails, input int vmode, input string tag);
    int target;
    push_run(fails ? MAX_SL : offset, fails);
    target = done_count + 1;
    $display("tb: run %s offset=%0d never_match=%0d valid_mode=%0d", tag, offset, fails, vmode);
    launch(offset, fails, vmode);
    wait_done(target, tag);
  endtask

  initial begin : monitor
    int  words;
    bit  prev_busy;
    bit  pend;
    ev_t e;
    words = 0; prev_busy = 1'b0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        words = 0; prev_busy = 1'b0; pend = 1'b0;
      end else begin
        if (pend) begin
          chk("pulse_width", bitslip_n_o, 1);
          pend = 1'b0;
        end
        if (!ser_ready_i) words = 0;
        if (!bitslip_n_o) begin
          pulse_count++;
          $display("tb: pulse #%0d after %0d valid words, slip_count=%0d", pulse_count, words, slip_count_o);
          chk("pulse_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pulse_kind", int'(e.kind), int'(EV_PULSE));
            chk("pulse_spacing", words, e.words);
          end
          words = 0;
          pend  = 1'b1;
        end else if (prev_busy && !busy_o) begin
          done_count++;
          $display("tb: done aligned=%0d fail=%0d slip_count=%0d words_since_last_slip=%0d",
                   aligned_o, train_fail_o, slip_count_o, words);
          chk("done_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_kind", int'(e.kind), int'(EV_DONE));
            chk("done_aligned", aligned_o, e.aligned);
            chk("done_fail", train_fail_o, e.fail);
            chk("done_slip_count", slip_count_o, e.slips);
            chk("done_words", words, e.words);
          end
          words = 0;
        end else if (busy_o && rx_word_valid_i && ser_ready_i) begin
          words++;
        end
        prev_busy = busy_o;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int target;
    reset_n = 1'b0; start = 1'b0; ser_ready_i = 1'b0;
    rx_word_i = '0; rx_word_valid_i = 1'b0; ready_drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_bitslip", bitslip_n_o, 1);
    chk("reset_aligned", aligned_o, 0);
    chk("reset_fail", train_fail_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_slip_count", slip_count_o, 0);
    reset_n = 1'b1;
    repeat (4) step(1'b0);
    chk("idle_busy", busy_o, 0);
    chk("idle_bitslip", bitslip_n_o, 1);

    run_train(0, 1'b0, 0, "aligned");
    never_match = 1'b1;
    repeat (4) step(1'b0);
    chk("lock_hold_aligned", aligned_o, 1);
    chk("lock_hold_bitslip", bitslip_n_o, 1);

    run_train(3, 1'b0, 0, "offset3");
    run_train(0, 1'b1, 0, "never_match");
    ready_drv = 1'b0;
    repeat (3) step(1'b0);
    chk("fail_hold", train_fail_o, 1);
    chk("fail_busy", busy_o, 0);
    chk("fail_aligned", aligned_o, 0);
    ready_drv = 1'b1;
    step(1'b0);

    run_train(0, 1'b0, 1, "valid_1of3");
    for (int i = 0; i < 6; i++) begin
      run_train(int'($urandom_range(0, 9)), ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)), "random");
    end

    run_train(5, 1'b0, 2, "pre_lock_drop");
    push_run(0, 1'b0);
    target = done_count + 1;
    ready_drv = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("lock_drop_aligned", aligned_o, 0);
    chk("lock_drop_busy", busy_o, 1);
    ready_drv = 1'b1; hold_invalid = 3;
    wait_done(target, "relock");

    $display("tb: run ready_drop offset=6");
    push_pulse();
    push_pulse();
    target = pulse_count + 2;
    launch(6, 1'b0, 0);
    wait_pulses(target, "ready_drop");
    step(1'b0);
    step(1'b0);
    ready_drv = 1'b0;
    repeat (5) step(1'b0);
    chk("drop_busy", busy_o, 1);
    chk("drop_slip_count", slip_count_o, 0);
    chk("drop_bitslip", bitslip_n_o, 1);
    chk("drop_aligned", aligned_o, 0);
    ready_drv = 1'b1; hold_invalid = 3;
    push_run(ph, 1'b0);
    target = done_count + 1;
    wait_done(target, "after_drop");

    $display("tb: run reset_mid_slip offset=3");
    push_pulse();
    launch(3, 1'b0, 0);
    begin
      int n = 0;
      while (bitslip_n_o && n < BUDGET) begin
        step(1'b0);
        n++;
      end
    end
    chk("slip_seen_before_reset", int'(!bitslip_n_o), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_bitslip", bitslip_n_o, 1);
    chk("rst_mid_aligned", aligned_o, 0);
    chk("rst_mid_fail", train_fail_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_slip_count", slip_count_o, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step(1'b0);
    chk("post_reset_idle_busy", busy_o, 0);
    chk("post_reset_bitslip", bitslip_n_o, 1);

    run_train(int'($urandom_range(1, 9)), 1'b0, 0, "after_reset");
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
